// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared widths, Op encodings, FSM state encoding and a
// conditional two's-complement helper for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PROD_W     = 2 * DATA_W;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);
  localparam int unsigned OP_W       = 3;

  // Codes 6 and 7 are reserved and decode to no operation.
  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Negate v when neg is set (magnitude <-> signed conversion).
  function automatic logic [DATA_W-1:0] neg_if(input logic neg,
                                               input logic [DATA_W-1:0] v);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the pipeline and the HI/LO unit.
//   Start, Op, OperandA, OperandB : request (master -> slave)
//   Hi, Lo, Busy, Done            : result/status (slave -> master)
interface muldiv_if;
  import muldiv_pkg::*;

  logic              Start;
  logic [OP_W-1:0]   Op;
  logic [DATA_W-1:0] OperandA;
  logic [DATA_W-1:0] OperandB;
  logic [DATA_W-1:0] Hi;
  logic [DATA_W-1:0] Lo;
  logic              Busy;
  logic              Done;

  modport master (
    output Start, Op, OperandA, OperandB,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  Start, Op, OperandA, OperandB,
    output Hi, Lo, Busy, Done
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration on unsigned magnitudes.
//   is_div      : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_hi      : partial product high half / partial remainder
//   acc_lo      : multiplier shifting out (product low in) / dividend shifting
//                 out (quotient bits in)
//   opnd        : multiplicand / divisor
//   acc_*_nxt   : accumulator after this step
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] acc_hi_nxt,
  output logic [DATA_W-1:0] acc_lo_nxt
);

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W+1:0] div_diff;
  logic              div_borrow;
  logic              unused_diff_msb;

  // After a successful subtract the remainder is below the divisor, so
  // bit DATA_W of the difference is always zero and only the borrow matters.
  assign unused_diff_msb = div_diff[DATA_W];

  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift  = {acc_hi, acc_lo[DATA_W-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, opnd};
    div_borrow = div_diff[DATA_W+1];
    if (is_div) begin
      acc_hi_nxt = div_borrow ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
      acc_lo_nxt = {acc_lo[DATA_W-2:0], ~div_borrow};
    end else begin
      acc_hi_nxt = mul_sum[DATA_W:1];
      acc_lo_nxt = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit.
//   Clock : sole clock, posedge
//   Reset : asynchronous active-low reset
//   bus   : muldiv_if.slave (Start/Op/OperandA/OperandB in, Hi/Lo/Busy/Done out)
// Signed ops work on magnitudes; signs are applied when the result is written.
// Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU finish in a single RUN cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic    Clock,
  input  logic    Reset,
  muldiv_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;          // negate product / quotient
  logic              rem_neg_q, rem_neg_d;  // negate remainder
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] step_hi, step_lo;
  logic              signed_op, a_neg, b_neg, b_zero;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [PROD_W-1:0] prod;
`ifdef MULDIV_FAST_MUL_EN
  logic [PROD_W-1:0] fast_prod;
`endif

  muldiv_step u_step (
    .is_div     (is_div_q),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .opnd       (opnd_q),
    .acc_hi_nxt (step_hi),
    .acc_lo_nxt (step_lo)
  );

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    // Busy trails the accept by one edge and drops as FINISH writes back.
    busy_d    = (state_q == ST_RUN);
    prod      = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = PROD_W'(opnd_q) * PROD_W'(acc_lo_q);
`endif

    signed_op = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    a_neg     = signed_op & bus.OperandA[DATA_W-1];
    b_neg     = signed_op & bus.OperandB[DATA_W-1];
    a_mag     = neg_if(a_neg, bus.OperandA);
    b_mag     = neg_if(b_neg, bus.OperandB);
    b_zero    = (bus.OperandB == '0);

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          case (bus.Op)
            OP_MULT, OP_MULTU: begin
              state_d   = ST_RUN;
              cnt_d     = '0;
              is_div_d  = 1'b0;
              acc_hi_d  = '0;
              acc_lo_d  = b_mag;
              opnd_d    = a_mag;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_d   = ST_RUN;
              cnt_d     = '0;
              is_div_d  = 1'b1;
              acc_hi_d  = '0;
              acc_lo_d  = a_mag;
              opnd_d    = b_mag;
              // Divide-by-zero yields an all-ones quotient with no sign fixup;
              // the remainder comes back as the dividend itself.
              neg_d     = (a_neg ^ b_neg) & ~b_zero;
              rem_neg_d = a_neg;
            end
            OP_MTHI: hi_d = bus.OperandA;
            OP_MTLO: lo_d = bus.OperandA;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div_q) begin
          {acc_hi_d, acc_lo_d} = fast_prod;
          state_d              = ST_FINISH;
        end else
`endif
        begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
            state_d = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        if (is_div_q) begin
          lo_d = neg_if(neg_q, acc_lo_q);
          hi_d = neg_if(rem_neg_q, acc_hi_q);
        end else begin
          if (neg_q) begin
            prod = ~prod + PROD_W'(1);
          end
          hi_d = prod[PROD_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule
